// File: rtl/multi_ch_data_sync_if.sv
// Purpose: bundles the per-channel request/data/ack handshake of multi_ch_data_sync.
// Latency: none; this is wiring only.
// Backpressure: sync_ready carries consumer backpressure; ack_out returns to the source.
interface multi_ch_data_sync_if #(
  parameter int NUM_CH = 2,
  parameter int Width  = 8
);
  logic [NUM_CH-1:0]       async_req;
  logic [NUM_CH*Width-1:0] Async_bus;
  logic [NUM_CH-1:0]       sync_ready;
  logic [NUM_CH-1:0]       overrun_clr;
  logic [NUM_CH*Width-1:0] sync_bus;
  logic [NUM_CH-1:0]       sync_valid;
  logic [NUM_CH-1:0]       ack_out;
  logic [NUM_CH-1:0]       overrun;

  // Source/consumer side: drives requests, data, ready and clears.
  modport master (
    output async_req, Async_bus, sync_ready, overrun_clr,
    input  sync_bus, sync_valid, ack_out, overrun
  );

  // Synchroniser side.
  modport slave (
    input  async_req, Async_bus, sync_ready, overrun_clr,
    output sync_bus, sync_valid, ack_out, overrun
  );
endinterface

// File: rtl/multi_ch_data_sync.sv
// Purpose: per-channel req/ack CDC receiver capturing a quasi-static data word into CLK domain.
// Latency: a req change sampled at edge k is captured with sync_valid=1 at edge k+NUM_Stages.
// Backpressure: word held until sync_ready; events arriving while held are dropped and flag overrun.
module multi_ch_data_sync #(
  parameter int NUM_Stages  = 2,
  parameter int Width       = 8,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = 1
) (
  input logic                 CLK,
  input logic                 Reset,
  multi_ch_data_sync_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [NUM_Stages-1:0]   sync_q [NUM_CH];
  logic [NUM_Stages-1:0]   sync_d [NUM_CH];
  logic [NUM_CH-1:0]       edge_q, edge_d;
  logic [NUM_CH-1:0]       state_q, state_d;
  logic [NUM_CH-1:0]       ack_q, ack_d;
  logic [NUM_CH-1:0]       ovr_q, ovr_d;
  logic [NUM_CH*Width-1:0] data_q, data_d;

  logic [NUM_CH-1:0]       evt;
  logic [NUM_CH-1:0]       consume;
  logic [NUM_CH-1:0]       capture;
  logic [NUM_CH-1:0]       drop;

  // Per-channel synchroniser, event detect, IDLE/HOLD FSM, ack and overrun next-state.
  always_comb begin
    edge_d  = edge_q;
    state_d = state_q;
    ack_d   = ack_q;
    ovr_d   = ovr_q & ~bus.overrun_clr;
    data_d  = data_q;
    evt     = '0;
    consume = '0;
    capture = '0;
    drop    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sync_d[c] = {sync_q[c][NUM_Stages-2:0], bus.async_req[c]};
      edge_d[c] = sync_q[c][NUM_Stages-1];

      // Toggle mode reacts to either transition; level mode only to the rise.
      if (TOGGLE_MODE != 0) begin
        evt[c] = sync_q[c][NUM_Stages-1] ^ edge_q[c];
      end else begin
        evt[c] = sync_q[c][NUM_Stages-1] & ~edge_q[c];
      end

      consume[c] = (state_q[c] == HOLD) & bus.sync_ready[c];
      capture[c] = evt[c] & ((state_q[c] == IDLE) | bus.sync_ready[c]);
      drop[c]    = evt[c] & (state_q[c] == HOLD) & ~bus.sync_ready[c];

      // A consume and a capture on the same edge keep the channel in HOLD.
      if (capture[c]) begin
        data_d[c*Width +: Width] = bus.Async_bus[c*Width +: Width];
        state_d[c]               = HOLD;
      end else if (consume[c]) begin
        state_d[c] = IDLE;
      end

      // Set beats clear when both land on the same edge.
      if (drop[c]) begin
        ovr_d[c] = 1'b1;
      end

      // Level mode drops ack once the delayed synchronised req is low; a low req
      // while ack is already 0 simply falls through and is ignored.
      if (consume[c]) begin
        ack_d[c] = (TOGGLE_MODE != 0) ? ~ack_q[c] : 1'b1;
      end else if ((TOGGLE_MODE == 0) && ack_q[c] && !edge_q[c]) begin
        ack_d[c] = 1'b0;
      end
    end
  end

  // State registers; reset abandons any held word without acknowledging it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync_q[c] <= '0;
      end
      edge_q  <= '0;
      state_q <= {NUM_CH{IDLE}};
      ack_q   <= '0;
      ovr_q   <= '0;
      data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync_q[c] <= sync_d[c];
      end
      edge_q  <= edge_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
    end
  end

  assign bus.sync_bus   = data_q;
  assign bus.sync_valid = state_q;
  assign bus.ack_out    = ack_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_multi_ch_data_sync.sv
// Purpose: directed bench for multi_ch_data_sync in toggle and level handshake modes.
// Latency: checks edge-exact capture, consume, ack and reset timing.
// Backpressure: exercises held words, overrun drops and simultaneous consume/capture.
module tb_multi_ch_data_sync;

  logic CLK;
  logic Reset;
  int   n_assert;
  int   n_fail;

  multi_ch_data_sync_if #(.NUM_CH(2), .Width(8)) bus_t ();
  multi_ch_data_sync_if #(.NUM_CH(2), .Width(8)) bus_l ();

  multi_ch_data_sync #(.NUM_Stages(2), .Width(8), .NUM_CH(2), .TOGGLE_MODE(1)) dut_t (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_t)
  );

  multi_ch_data_sync #(.NUM_Stages(2), .Width(8), .NUM_CH(2), .TOGGLE_MODE(0)) dut_l (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_l)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1 time unit past the next rising edge: outputs are sampled and
  // new inputs driven there, to be picked up by the following edge.
  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    bus_t.async_req = '0; bus_t.Async_bus = '0; bus_t.sync_ready = '0; bus_t.overrun_clr = '0;
    bus_l.async_req = '0; bus_l.Async_bus = '0; bus_l.sync_ready = '0; bus_l.overrun_clr = '0;
    edge1();
    edge1();

    // Reset state
    chk("rst_t_valid", bus_t.sync_valid, 2'b00);
    chk("rst_t_ack",   bus_t.ack_out,    2'b00);
    chk("rst_t_ovr",   bus_t.overrun,    2'b00);
    chk("rst_t_bus",   bus_t.sync_bus,   16'h0000);
    chk("rst_l_valid", bus_l.sync_valid, 2'b00);
    chk("rst_l_ack",   bus_l.ack_out,    2'b00);
    Reset = 1'b0;
    edge1();
    edge1();

    // Toggle mode basic capture and consume on ch0
    bus_t.Async_bus[7:0] = 8'hA5;
    bus_t.async_req[0]   = 1'b1;
    edge1();
    chk("t_lat_k0", bus_t.sync_valid[0], 1'b0);
    edge1();
    chk("t_lat_k1", bus_t.sync_valid[0], 1'b0);
    edge1();
    chk("t_cap_valid", bus_t.sync_valid[0], 1'b1);
    chk("t_cap_bus",   bus_t.sync_bus[7:0], 8'hA5);
    chk("t_cap_ack",   bus_t.ack_out[0],    1'b0);
    edge1();
    bus_t.sync_ready[0] = 1'b1;
    edge1();
    chk("t_cons_valid", bus_t.sync_valid[0], 1'b0);
    chk("t_cons_ack",   bus_t.ack_out[0],    1'b1);
    bus_t.sync_ready[0]  = 1'b0;
    bus_t.Async_bus[7:0] = 8'hFF;
    edge1();
    edge1();
    chk("t_idle_hold_bus", bus_t.sync_bus[7:0], 8'hA5);
    chk("t_idle_ack",      bus_t.ack_out[0],    1'b1);

    // Overrun on ch1
    bus_t.Async_bus[15:8] = 8'h3C;
    bus_t.async_req[1]    = 1'b1;
    edge1(); edge1(); edge1();
    chk("ovr_first_valid", bus_t.sync_valid[1],  1'b1);
    chk("ovr_first_bus",   bus_t.sync_bus[15:8], 8'h3C);
    bus_t.Async_bus[15:8] = 8'h77;
    bus_t.async_req[1]    = 1'b0;
    edge1(); edge1(); edge1();
    chk("ovr_flag",  bus_t.overrun[1],     1'b1);
    chk("ovr_bus",   bus_t.sync_bus[15:8], 8'h3C);
    chk("ovr_ack",   bus_t.ack_out[1],     1'b0);
    chk("ovr_valid", bus_t.sync_valid[1],  1'b1);
    chk("ovr_ch0",   bus_t.overrun[0],     1'b0);
    bus_t.overrun_clr[1] = 1'b1;
    edge1();
    chk("ovr_clr", bus_t.overrun[1], 1'b0);
    bus_t.overrun_clr[1] = 1'b0;
    bus_t.sync_ready[1]  = 1'b1;
    edge1();
    chk("ovr_cons_valid", bus_t.sync_valid[1], 1'b0);
    chk("ovr_cons_ack",   bus_t.ack_out[1],    1'b1);
    bus_t.sync_ready[1] = 1'b0;

    // Simultaneous consume and capture on ch0
    bus_t.Async_bus[7:0] = 8'h11;
    bus_t.async_req[0]   = 1'b0;
    edge1(); edge1(); edge1();
    chk("sim_first_bus", bus_t.sync_bus[7:0], 8'h11);
    bus_t.Async_bus[7:0] = 8'h22;
    bus_t.async_req[0]   = 1'b1;
    edge1();
    edge1();
    bus_t.sync_ready[0] = 1'b1;
    edge1();
    chk("sim_bus",   bus_t.sync_bus[7:0], 8'h22);
    chk("sim_valid", bus_t.sync_valid[0], 1'b1);
    chk("sim_ack",   bus_t.ack_out[0],    1'b0);
    chk("sim_ovr",   bus_t.overrun[0],    1'b0);
    bus_t.sync_ready[0] = 1'b0;
    edge1();
    chk("sim_hold_valid", bus_t.sync_valid[0], 1'b1);
    chk("sim_hold_ack",   bus_t.ack_out[0],    1'b0);
    bus_t.sync_ready[0] = 1'b1;
    edge1();
    chk("sim_cons_ack", bus_t.ack_out[0], 1'b1);
    bus_t.sync_ready[0] = 1'b0;

    // Channel independence: both channels fire on the same edge
    bus_t.Async_bus = {8'hC3, 8'h5A};
    bus_t.async_req = ~bus_t.async_req;
    edge1(); edge1(); edge1();
    chk("ind_bus",   bus_t.sync_bus,   16'hC35A);
    chk("ind_valid", bus_t.sync_valid, 2'b11);
    chk("ind_ovr",   bus_t.overrun,    2'b00);

    // Reset mid-HOLD with ack high, req then held at 1
    chk("pre_rst_ack", bus_t.ack_out, 2'b11);
    Reset           = 1'b1;
    bus_t.async_req = 2'b11;
    edge1();
    chk("mid_rst_valid", bus_t.sync_valid, 2'b00);
    chk("mid_rst_ack",   bus_t.ack_out,    2'b00);
    chk("mid_rst_bus",   bus_t.sync_bus,   16'h0000);
    chk("mid_rst_ovr",   bus_t.overrun,    2'b00);
    Reset           = 1'b0;
    bus_t.Async_bus = {8'h99, 8'h66};
    edge1();
    chk("post_rst_k0", bus_t.sync_valid, 2'b00);
    edge1();
    chk("post_rst_k1", bus_t.sync_valid, 2'b00);
    edge1();
    chk("post_rst_valid", bus_t.sync_valid, 2'b11);
    chk("post_rst_bus",   bus_t.sync_bus,   16'h9966);
    chk("post_rst_ack",   bus_t.ack_out,    2'b00);

    // Level mode full 4-phase cycle on ch0
    bus_l.Async_bus[7:0] = 8'hB4;
    bus_l.async_req[0]   = 1'b1;
    edge1();
    edge1();
    chk("l_lat_k1", bus_l.sync_valid[0], 1'b0);
    edge1();
    chk("l_cap_valid", bus_l.sync_valid[0], 1'b1);
    chk("l_cap_bus",   bus_l.sync_bus[7:0], 8'hB4);
    bus_l.sync_ready[0] = 1'b1;
    edge1();
    chk("l_cons_valid", bus_l.sync_valid[0], 1'b0);
    chk("l_cons_ack",   bus_l.ack_out[0],    1'b1);
    bus_l.sync_ready[0] = 1'b0;
    bus_l.async_req[0]  = 1'b0;
    edge1();
    chk("l_fall_j0", bus_l.ack_out[0], 1'b1);
    edge1();
    chk("l_fall_j1", bus_l.ack_out[0], 1'b1);
    edge1();
    chk("l_fall_j2", bus_l.ack_out[0], 1'b1);
    chk("l_fall_novalid", bus_l.sync_valid[0], 1'b0);
    edge1();
    chk("l_fall_j3", bus_l.ack_out[0], 1'b0);
    bus_l.Async_bus[7:0] = 8'h4B;
    bus_l.async_req[0]   = 1'b1;
    edge1(); edge1(); edge1();
    chk("l_second_valid", bus_l.sync_valid[0], 1'b1);
    chk("l_second_bus",   bus_l.sync_bus[7:0], 8'h4B);

    // Level mode req fall while ack is 0 is ignored
    bus_l.async_req[0] = 1'b0;
    edge1(); edge1(); edge1(); edge1();
    chk("l_viol_valid", bus_l.sync_valid[0], 1'b1);
    chk("l_viol_bus",   bus_l.sync_bus[7:0], 8'h4B);
    chk("l_viol_ack",   bus_l.ack_out[0],    1'b0);
    chk("l_viol_ovr",   bus_l.overrun[0],    1'b0);
    chk("l_ch1_quiet",  bus_l.sync_valid[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
